// File: rtl/pipe_stage_buf_if.sv
// pipe_stage_buf_if: handshake and data bundle across one pipeline stage boundary
interface pipe_stage_buf_if #(
  parameter int INSTR_W = 16,
  parameter int PC_W = 16,
  parameter int CNT_W = 16
);
  logic in_valid;
  logic [INSTR_W-1:0] in_instr;
  logic [PC_W-1:0] in_pc;
  logic in_ready;
  logic flush;
  logic stall;
  logic out_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0] out_pc;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;
  modport slave (
    input in_valid, in_instr, in_pc, flush, stall,
    output in_ready, out_valid, out_instr, out_pc, stall_cycles, flush_count
  );
  modport master (
    output in_valid, in_instr, in_pc, flush, stall,
    input in_ready, out_valid, out_instr, out_pc, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: registered-ready pipeline stage with 1-entry skid buffer; PIPE_STAGE_BUF_PERF_CNT_EN adds stall/flush counters
module pipe_stage_buf #(
  parameter int INSTR_W = 16,
  parameter int PC_W = 16,
  parameter logic [INSTR_W-1:0] NOP = 16'b0000_1000_0000_0000,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  pipe_stage_buf_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;
  state_t state, nxt;
  logic rdy, out_valid, accept, consume, ld_in, ld_skid, sk_in;
  logic [INSTR_W-1:0] main_instr, skid_instr;
  logic [PC_W-1:0] main_pc, skid_pc;
  // state register; ready is registered from the next state so upstream never sees stall combinationally
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      rdy <= 1'b1;
    end else begin
      state <= nxt;
      rdy <= nxt != SKID;
    end
  end
  // next state: flush empties the stage, otherwise occupancy follows accept/consume
  always_comb begin
    nxt = state;
    if (bus.flush) nxt = EMPTY;
    else if (state == EMPTY) nxt = accept ? FULL : EMPTY;
    else if (state == FULL) nxt = consume ? (accept ? FULL : EMPTY) : (accept ? SKID : FULL);
    else nxt = consume ? FULL : SKID;
  end
  // handshake decode and register load enables
  always_comb begin
    out_valid = state != EMPTY;
    accept = bus.in_valid && rdy;
    consume = out_valid && !bus.stall;
    ld_in = !bus.flush && accept && (state == EMPTY || (state == FULL && consume));
    ld_skid = !bus.flush && state == SKID && consume;
    sk_in = !bus.flush && accept && state == FULL && !consume;
  end
  // datapath: main feeds the outputs, skid catches the entry that arrives while main is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      main_instr <= NOP;
      main_pc <= '0;
      skid_instr <= NOP;
      skid_pc <= '0;
    end else begin
      if (ld_in) begin
        main_instr <= bus.in_instr;
        main_pc <= bus.in_pc;
      end else if (ld_skid) begin
        main_instr <= skid_instr;
        main_pc <= skid_pc;
      end
      if (sk_in) begin
        skid_instr <= bus.in_instr;
        skid_pc <= bus.in_pc;
      end
    end
  end
  assign bus.in_ready = rdy;
  assign bus.out_valid = out_valid;
  assign bus.out_instr = out_valid ? main_instr : NOP;
  assign bus.out_pc = main_pc;
`ifdef PIPE_STAGE_BUF_PERF_CNT_EN
  logic [CNT_W-1:0] sc, fc;
  // saturating counters of stalled-valid cycles and flushes that actually discarded something
  always_ff @(posedge clk) begin
    if (rst) begin
      sc <= '0;
      fc <= '0;
    end else begin
      if (out_valid && bus.stall && !bus.flush && !(&sc)) sc <= sc + 1'b1;
      if (bus.flush && (state != EMPTY || accept) && !(&fc)) fc <= fc + 1'b1;
    end
  end
  assign bus.stall_cycles = sc;
  assign bus.flush_count = fc;
`else
  assign bus.stall_cycles = {CNT_W{1'b0}};
  assign bus.flush_count = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed plus random stimulus against a 2-deep FIFO reference model
module tb_pipe_stage_buf;
  localparam int CNT_W = 4;
  localparam logic [15:0] NOP = 16'h0800;
  localparam int SAT = (1 << CNT_W) - 1;
`ifdef PIPE_STAGE_BUF_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  typedef struct {
    logic [15:0] i;
    logic [15:0] p;
  } ent_t;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  ent_t q[$];
  bit m_rdy = 1'b1;
  logic [15:0] m_pc = '0;
  int m_sc = 0;
  int m_fc = 0;
  pipe_stage_buf_if #(.INSTR_W(16), .PC_W(16), .CNT_W(CNT_W)) bus ();
  pipe_stage_buf #(.INSTR_W(16), .PC_W(16), .NOP(NOP), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, o, e);
    end
  endtask
  task automatic drv(input bit v, input logic [15:0] i, input bit f, input bit s, input bit r);
    bus.in_valid = v;
    bus.in_instr = i;
    bus.in_pc = i ^ 16'h0f0f;
    bus.flush = f;
    bus.stall = s;
    rst = r;
  endtask
  task automatic step();
    bit acc, con;
    ent_t e;
    @(posedge clk);
    acc = bus.in_valid && m_rdy;
    con = q.size() > 0 && !bus.stall;
    if (rst) begin
      q.delete();
      m_rdy = 1'b1;
      m_pc = '0;
      m_sc = 0;
      m_fc = 0;
    end else if (bus.flush) begin
      if ((q.size() > 0 || acc) && m_fc < SAT) m_fc++;
      q.delete();
      m_rdy = 1'b1;
    end else begin
      if (q.size() > 0 && bus.stall && m_sc < SAT) m_sc++;
      if (con) void'(q.pop_front());
      if (acc) begin
        e.i = bus.in_instr;
        e.p = bus.in_pc;
        q.push_back(e);
      end
      m_rdy = q.size() < 2;
      if (q.size() > 0) m_pc = q[0].p;
    end
    @(negedge clk);
    chk("valid", {31'b0, bus.out_valid}, {31'b0, q.size() > 0});
    chk("instr", {16'b0, bus.out_instr}, {16'b0, q.size() > 0 ? q[0].i : NOP});
    chk("pc", {16'b0, bus.out_pc}, {16'b0, m_pc});
    chk("ready", {31'b0, bus.in_ready}, {31'b0, m_rdy});
    chk("stall_cycles", {28'b0, bus.stall_cycles}, PERF ? m_sc : 0);
    chk("flush_count", {28'b0, bus.flush_count}, PERF ? m_fc : 0);
  endtask
  initial begin
    int fc0;
    drv(0, 16'h0, 0, 0, 1);
    step();
    chk("reset_instr", {16'b0, bus.out_instr}, 32'h0800);
    drv(1, 16'h1111, 0, 0, 0);
    step();
    drv(1, 16'h2222, 0, 0, 0);
    step();
    drv(1, 16'h3333, 0, 0, 0);
    step();
    chk("stream_ready", {31'b0, bus.in_ready}, 32'h1);
    drv(0, 16'h0, 0, 0, 0);
    step();
    step();
    drv(1, 16'hAAAA, 0, 0, 0);
    step();
    drv(1, 16'hBBBB, 0, 1, 0);
    step();
    chk("skid_hold", {16'b0, bus.out_instr}, 32'hAAAA);
    chk("skid_ready", {31'b0, bus.in_ready}, 32'h0);
    drv(0, 16'h0, 0, 0, 0);
    step();
    chk("skid_drain", {16'b0, bus.out_instr}, 32'hBBBB);
    drv(1, 16'hCCCC, 0, 1, 0);
    step();
    drv(1, 16'hDDDD, 1, 1, 0);
    step();
    chk("flush_nop", {16'b0, bus.out_instr}, 32'h0800);
    drv(0, 16'h0, 0, 0, 0);
    step();
    step();
    drv(1, 16'hEEEE, 0, 0, 0);
    step();
    drv(0, 16'h0, 1, 1, 0);
    step();
    drv(1, 16'h1234, 0, 0, 0);
    step();
    drv(1, 16'h4321, 0, 1, 0);
    step();
    drv(1, 16'h9999, 0, 1, 1);
    step();
    drv(1, 16'h5A5A, 0, 0, 0);
    step();
    chk("post_reset", {16'b0, bus.out_instr}, 32'h5A5A);
    drv(0, 16'h0, 0, 0, 0);
    step();
    fc0 = m_fc;
    drv(0, 16'h0, 1, 0, 0);
    step();
    chk("flush_empty", {28'b0, bus.flush_count}, PERF ? fc0 : 0);
    drv(1, 16'h7777, 0, 1, 0);
    step();
    drv(0, 16'h0, 0, 1, 0);
    for (int k = 0; k < 20; k++) step();
    chk("stall_sat", {28'b0, bus.stall_cycles}, PERF ? 32'd15 : 32'd0);
    drv(0, 16'h0, 0, 0, 1);
    step();
    for (int k = 0; k < 400; k++) begin
      drv($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 19) == 0,
          $urandom_range(0, 2) == 0, $urandom_range(0, 99) == 0);
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
